// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake plus instruction-memory write port.
interface imem_loader_if #(parameter int ADDR_W = 7);
  logic byte_valid;
  logic byte_ready;
  logic [7:0] byte_data;
  logic we0;
  logic [ADDR_W-1:0] wr_addr0;
  logic [31:0] wr_din0;
  modport master(output byte_valid, byte_data, input byte_ready, we0, wr_addr0, wr_din0);
  modport slave(input byte_valid, byte_data, output byte_ready, we0, wr_addr0, wr_din0);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: loads a length-framed, XOR-checked byte image into imem and holds the core until done.
module imem_loader #(
  parameter int ADDR_W = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  imem_loader_if.slave bus,
  output logic core_hold,
  output logic busy,
  output logic done,
  output logic err,
  output logic [ADDR_W:0] words_loaded
);
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHECK, RUN, ERROR} state_t;
  localparam logic [ADDR_W:0] ONE = 1;
  state_t state, nxt;
  logic [7:0] len_lo, x;
  logic [15:0] len, n_rx;
  logic [1:0] bcnt;
  logic [23:0] sr;
  logic [ADDR_W:0] idx, idx_n;
  logic acc;
  assign acc = bus.byte_valid && bus.byte_ready;
  assign n_rx = {bus.byte_data, len_lo};
  assign idx_n = idx + ONE;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, RUN, ERROR: if (start) nxt = LEN_LO;
      LEN_LO: if (acc) nxt = LEN_HI;
      LEN_HI: if (acc) nxt = 32'(n_rx) > (32'd1 << ADDR_W) ? ERROR : n_rx == 16'd0 ? CHECK : DATA;
      DATA: if (acc && bcnt == 2'd3 && 16'(idx_n) == len) nxt = CHECK;
      CHECK: if (acc) nxt = bus.byte_data == x ? RUN : ERROR;
      default: nxt = IDLE;
    endcase
  end
  // Status outputs are registered from the next state so they change with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      bus.byte_ready <= 1'b0;
      bus.we0 <= 1'b0;
      bus.wr_addr0 <= '0;
      bus.wr_din0 <= '0;
      core_hold <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      words_loaded <= '0;
      len_lo <= '0;
      len <= '0;
      x <= '0;
      bcnt <= '0;
      sr <= '0;
      idx <= '0;
    end else begin
      state <= nxt;
      bus.we0 <= 1'b0;
      bus.byte_ready <= nxt inside {LEN_LO, LEN_HI, DATA, CHECK};
      busy <= nxt inside {LEN_LO, LEN_HI, DATA, CHECK};
      core_hold <= nxt != RUN;
      done <= nxt == RUN;
      err <= nxt == ERROR;
      if (nxt == LEN_LO && state != LEN_LO) begin
        x <= '0;
        idx <= '0;
        bcnt <= '0;
        words_loaded <= '0;
      end
      if (state == LEN_LO && acc) len_lo <= bus.byte_data;
      if (state == LEN_HI && acc) len <= n_rx;
      if (state == DATA && acc) begin
        x <= x ^ bus.byte_data;
        bcnt <= bcnt + 2'd1;
        sr <= {bus.byte_data, sr[23:8]};
        if (bcnt == 2'd3) begin
          bus.we0 <= 1'b1;
          bus.wr_addr0 <= idx[ADDR_W-1:0];
          bus.wr_din0 <= {bus.byte_data, sr};
          idx <= idx_n;
          words_loaded <= idx_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench; expected writes are queued at stimulus time, a monitor pops them on we0.
module tb_imem_loader;
  localparam int AW = 7;
  logic clk = 0, reset = 0, start = 0;
  logic core_hold, busy, done, err;
  logic [AW:0] words_loaded;
  imem_loader_if #(.ADDR_W(AW)) bus();
  imem_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus.slave),
    .core_hold(core_hold), .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic [38:0] exp_q[$];
  logic [7:0] frame[$];
  logic [31:0] wq[$];
  logic [38:0] e;
  logic we_prev = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.we0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_we0: addr %h data %h, none expected", bus.wr_addr0, bus.wr_din0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr0", 32'(bus.wr_addr0), 32'(e[38:32]));
        chk("wr_din0", bus.wr_din0, e[31:0]);
      end
      if (we_prev) begin
        checks++;
        failures++;
        $display("FAIL we0_width: we0 high for 2+ cycles, required 1");
      end
    end
    we_prev <= bus.we0;
  end

  // Frame: N lo, N hi, little-endian payload, XOR checksum (or a forced bad one).
  task automatic build(input bit bad, input logic [7:0] badck);
    logic [7:0] x = 0;
    int n = wq.size();
    frame = {};
    frame.push_back(8'(n));
    frame.push_back(8'(n >> 8));
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 4; b++) begin
        frame.push_back(wq[i][8*b +: 8]);
        x ^= wq[i][8*b +: 8];
      end
      exp_q.push_back({7'(i), wq[i]});
    end
    frame.push_back(bad ? badck : x);
  endtask

  task automatic send_frame(input bit gaps, input int start_idx);
    for (int i = 0; i < frame.size(); i++) begin
      int t = 0;
      @(negedge clk);
      while (gaps && $urandom_range(0, 2) == 0) begin
        bus.byte_valid = 0;
        @(negedge clk);
      end
      bus.byte_valid = 1;
      bus.byte_data = frame[i];
      start = (i == start_idx);
      while (!bus.byte_ready && t < 20) begin
        @(negedge clk);
        start = 0;
        t++;
      end
      if (!bus.byte_ready) begin
        checks++;
        failures++;
        $display("FAIL ready_timeout: byte %0d never accepted", i);
      end
      @(posedge clk);
    end
    @(negedge clk);
    bus.byte_valid = 0;
    start = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("start_ready", bus.byte_ready, 1);
    chk("start_busy", busy, 1);
    chk("start_hold", core_hold, 1);
    chk("start_wl_clear", words_loaded, 0);
  endtask

  task automatic check_run(input int wl);
    chk("done", done, 1);
    chk("core_hold", core_hold, 0);
    chk("err", err, 0);
    chk("words_loaded", words_loaded, wl);
    chk("pending_writes", exp_q.size(), 0);
  endtask

  task automatic nominal_words();
    wq = {32'h00500093, 32'h00A00113};
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.byte_valid = 0;
    bus.byte_data = 0;
    repeat (2) @(negedge clk);
    chk("rst_hold", core_hold, 1);
    chk("rst_ready", bus.byte_ready, 0);
    chk("rst_we0", bus.we0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_wl", words_loaded, 0);
    chk("rst_addr", 32'(bus.wr_addr0), 0);
    chk("rst_din", bus.wr_din0, 0);
    reset = 1;
    // Nominal two-word image; payload XOR is 0x71.
    nominal_words();
    build(0, 0);
    chk("nominal_cks", 32'(frame[frame.size()-1]), 32'h71);
    pulse_start();
    send_frame(0, -1);
    check_run(2);
    // Reload from RUN with a one-word image.
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("reload_hold", core_hold, 1);
    chk("reload_done", done, 0);
    chk("reload_busy", busy, 1);
    wq = {32'h12345678};
    build(0, 0);
    chk("oneword_cks", 32'(frame[frame.size()-1]), 32'h08);
    send_frame(0, -1);
    check_run(1);
    // Bad checksum: writes still occur.
    nominal_words();
    build(1, 8'hE0);
    pulse_start();
    send_frame(0, -1);
    chk("bad_err", err, 1);
    chk("bad_hold", core_hold, 1);
    chk("bad_done", done, 0);
    chk("bad_wl", words_loaded, 2);
    chk("bad_pending", exp_q.size(), 0);
    // Oversize N = 0x81 > 128.
    frame = {8'h81, 8'h00};
    pulse_start();
    send_frame(0, -1);
    chk("over_err", err, 1);
    chk("over_busy", busy, 0);
    chk("over_ready", bus.byte_ready, 0);
    // Boundary N = 0x80 is accepted, but only its length bytes are sent here.
    frame = {8'h80, 8'h00};
    pulse_start();
    send_frame(0, -1);
    chk("n128_err", err, 0);
    chk("n128_busy", busy, 1);
    // Empty frame, from the pending 128-word load.
    frame = {8'h00, 8'h00, 8'h00};
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    reset = 1;
    pulse_start();
    send_frame(0, -1);
    check_run(0);
    // Random gaps on byte_valid.
    nominal_words();
    build(0, 0);
    pulse_start();
    send_frame(1, -1);
    check_run(2);
    // Start during DATA is ignored.
    nominal_words();
    build(0, 0);
    pulse_start();
    send_frame(0, 4);
    check_run(2);
    // Reset after 5 payload bytes: only word 0 written.
    nominal_words();
    build(0, 0);
    void'(exp_q.pop_back());
    while (frame.size() > 7) void'(frame.pop_back());
    pulse_start();
    send_frame(0, -1);
    reset = 0;
    #1;
    chk("mid_rst_hold", core_hold, 1);
    chk("mid_rst_ready", bus.byte_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pending", exp_q.size(), 0);
    @(negedge clk);
    reset = 1;
    nominal_words();
    build(0, 0);
    pulse_start();
    send_frame(0, -1);
    check_run(2);
    repeat (4) @(negedge clk);
    chk("final_pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
